// File: rtl/rptr_empty.sv
// rptr_empty: read-side pointer and empty / almost-empty / count logic of an
// asynchronous FIFO. Runs entirely in the rclk domain; the write pointer
// arrives already synchronized, in Gray code.
// Optional feature: define RPTR_EMPTY_UNDERFLOW_EN to enable the sticky
// underflow flag. Without it the runderflow port is tied to 0.
module rptr_empty #(
  parameter int ASIZE                  = 5,
  parameter int ALMOST_EMPTY_THRESHOLD = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  input  logic [ASIZE:0]   rq2_wptr,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             ralmostempty,
  output logic [ASIZE:0]   rcount,
  output logic             runderflow
);

  localparam logic [ASIZE:0] AE_TH = (ASIZE+1)'(ALMOST_EMPTY_THRESHOLD);

  logic [ASIZE:0] r_rbin;
  logic           w_rd;
  logic [ASIZE:0] w_rbinnext;
  logic [ASIZE:0] w_rgraynext;
  logic [ASIZE:0] w_wbin;
  logic [ASIZE:0] w_count;

  // A read only advances the pointer when there is something to read.
  assign w_rd        = rinc & ~rempty;
  assign w_rbinnext  = r_rbin + {{ASIZE{1'b0}}, w_rd};
  assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wbin = '0;
    for (int k = 0; k <= ASIZE; k++) begin
      w_wbin[k] = ^(rq2_wptr >> k);
    end
  end

  // Plain modular difference; the extra MSB makes full (2^ASIZE) representable.
  assign w_count = w_wbin - w_rbinnext;

  // Pointer, flags and count all evaluate against the post-read pointer.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_rbin       <= '0;
      rptr         <= '0;
      rempty       <= 1'b1;
      ralmostempty <= 1'b1;
      rcount       <= '0;
    end else begin
      r_rbin       <= w_rbinnext;
      rptr         <= w_rgraynext;
      rempty       <= (w_rgraynext == rq2_wptr);
      ralmostempty <= (w_count <= AE_TH);
      rcount       <= w_count;
    end
  end

  assign raddr = r_rbin[ASIZE-1:0];

`ifdef RPTR_EMPTY_UNDERFLOW_EN
  logic r_underflow;

  // Sticky: any read attempted while empty latches until reset.
  always_ff @(posedge rclk) begin
    if (!rrst_n) r_underflow <= 1'b0;
    else         r_underflow <= r_underflow | (rinc & rempty);
  end

  assign runderflow = r_underflow;
`else
  assign runderflow = 1'b0;
`endif

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 The block SHALL have parameter ASIZE, default 5, the address width; FIFO depth is 2^ASIZE.
REQ-002 The block SHALL have parameter ALMOST_EMPTY_THRESHOLD, default 4, the word count at or below which almost-empty asserts.
REQ-003 The block SHALL have port rclk  input  1  read-domain clock; the block uses one clock only.
REQ-004 The block SHALL have port rrst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of rclk.
REQ-005 The block SHALL have port rinc  input  1  read request.
REQ-006 The block SHALL have port rq2_wptr  input  ASIZE+1  write pointer in Gray code, already synchronized into rclk.
REQ-007 The block SHALL have port raddr  output  ASIZE  memory read address, equal to rbin[ASIZE-1:0].
REQ-008 The block SHALL have port rptr  output  ASIZE+1  registered Gray read pointer, sent to the write domain.
REQ-009 The block SHALL have port rempty  output  1  registered empty flag.
REQ-010 The block SHALL have port ralmostempty  output  1  registered almost-empty flag.
REQ-011 The block SHALL have port rcount  output  ASIZE+1  registered count of readable words, range 0..2^ASIZE.
REQ-012 The block SHALL have port runderflow  output  1  sticky underflow flag.

Function
REQ-013 The block SHALL hold an internal binary pointer rbin of width ASIZE+1; rbinnext = rbin+1 when rinc=1 and rempty=0, otherwise rbin.
REQ-014 The block SHALL compute rgraynext = (rbinnext>>1) ^ rbinnext and register {rbin, rptr} <= {rbinnext, rgraynext} every rclk edge.
REQ-015 The binary pointer SHALL wrap modulo 2^(ASIZE+1): 2^(ASIZE+1)-1 -> 0, with the Gray code following; raddr wraps 2^ASIZE-1 -> 0.
REQ-016 rempty SHALL register (rgraynext == rq2_wptr) each cycle; the flag reflects a read issued in a given cycle at the next edge.
REQ-017 A read request while rempty=1 SHALL be ignored: rbin, rptr and raddr hold.
REQ-018 The block SHALL convert rq2_wptr to binary combinationally as rq2_wbin[ASIZE] = rq2_wptr[ASIZE] and rq2_wbin[k] = rq2_wbin[k+1] ^ rq2_wptr[k].
REQ-019 Count SHALL be (rq2_wbin - rbinnext) modulo 2^(ASIZE+1), no extra wrap correction, registered into rcount each cycle.
REQ-020 ralmostempty SHALL register (count <= ALMOST_EMPTY_THRESHOLD) from the same count; rempty=1 SHALL imply ralmostempty=1.
REQ-021 rinc=1 in the same cycle that rq2_wptr changes SHALL evaluate all flags against the new rq2_wptr and rbinnext.
REQ-022 All outputs SHALL be registers or direct slices of registers; the block SHALL contain no combinational path from input to output.

Reset
REQ-023 With rrst_n=0 at an rclk edge, the block SHALL set rbin=0, rptr=0, raddr=0, rempty=1, ralmostempty=1, rcount=0 and runderflow=0, regardless of rinc.
REQ-024 Reset asserted mid-operation SHALL discard the pointer state; the first edge after release evaluates normally against rq2_wptr.

Configuration
REQ-025 With macro RPTR_EMPTY_UNDERFLOW_EN defined, runderflow SHALL set on the edge after any cycle with rinc=1 and rempty=1, and stay set until reset.
REQ-026 With RPTR_EMPTY_UNDERFLOW_EN undefined, port runderflow SHALL remain present and be driven constant 0; all other behaviour is unchanged.

Verification
REQ-027 The bench SHALL cover reset: rrst_n=0 for 2 cycles with rinc=1 and rq2_wptr=6'b000110 -> rptr=0, raddr=0, rempty=1, ralmostempty=1, rcount=0, runderflow=0.
REQ-028 The bench SHALL cover fill then drain: rq2_wptr=gray(3)=6'b000010 with rinc=0 -> after 1 edge rempty=0, rcount=3, ralmostempty=1; then rinc=1 for 3 cycles -> raddr 0,1,2, rempty=1 after the 3rd edge, then rinc=1 holds raddr=3.
REQ-029 The bench SHALL cover the threshold crossing: rq2_wptr=gray(20) -> rcount=20, ralmostempty=0; after 15 reads rcount=5, ralmostempty=0; after the 16th read rcount=4, ralmostempty=1.
REQ-030 The bench SHALL cover pointer wrap: rbin=63 (rptr=6'b100000) and rq2_wptr=gray(1)=6'b000001 -> rcount=2; two reads -> rptr 000000 then 000001, raddr 31 -> 0 -> 1, then rempty=1.
REQ-031 The bench SHALL cover underflow: rempty=1 and rinc=1 for one cycle -> rptr unchanged, runderflow=1 at the next edge and still 1 after rinc=0 (0 when the macro is undefined); then rrst_n=0 -> runderflow=0.
